load_store_unit: RTL and testbench

- Sits between the execute stage and the word-addressed data memory.
- Accepts one RV32I load or store request at a time and converts byte addresses to word addresses.
- Sub-word stores (SB/SH) are done as read-modify-write; loads are sign- or zero-extended.
- Misaligned accesses and illegal funct3 codes are reported as faults and never touch memory.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bundle for the load/store unit
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_fault;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [31:0]           mem_write_data;
    logic [31:0]           mem_read_data;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_addr, mem_read_en, mem_write_en, mem_write_data
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_addr, mem_read_en, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit, word-addressed memory, RMW for SB/SH
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH+1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  store_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged_q;
    logic [31:0]           rdata_q;
    logic                  fault_q;

    logic                  accept;
    logic                  fault_now;
    logic                  write_raw;
    logic                  read_en;
    logic [31:0]           write_data;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_val;
    logic [31:0]           merge_val;

    // Upper address bits wrap around silently; they are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

    assign accept = bus.req_valid & bus.req_ready;

    function automatic logic check_fault(input logic st, input logic [2:0] f3,
                                         input logic [1:0] a);
        logic flt;
        flt = 1'b0;
        if (st) begin
            case (f3)
                3'b000:  flt = 1'b0;
                3'b001:  flt = a[0];
                3'b010:  flt = (a != 2'b00);
                default: flt = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b100: flt = 1'b0;
                3'b001, 3'b101: flt = a[0];
                3'b010:         flt = (a != 2'b00);
                default:        flt = 1'b1;
            endcase
        end
        return flt;
    endfunction

    assign fault_now = check_fault(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

    always_comb begin
        lane_b = 8'h00;
        case (addr_q[1:0])
            2'd0: lane_b = bus.mem_read_data[7:0];
            2'd1: lane_b = bus.mem_read_data[15:8];
            2'd2: lane_b = bus.mem_read_data[23:16];
            2'd3: lane_b = bus.mem_read_data[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    end

    // funct3[2] selects zero-extension (LBU/LHU); funct3[1:0] selects the width.
    always_comb begin
        load_val = 32'h0;
        case (funct3_q[1:0])
            2'b00:   load_val = funct3_q[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = funct3_q[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = bus.mem_read_data;
        endcase
    end

    always_comb begin
        merge_val = bus.mem_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merge_val[7:0]   = wdata_q[7:0];
                2'd1: merge_val[15:8]  = wdata_q[7:0];
                2'd2: merge_val[23:16] = wdata_q[7:0];
                2'd3: merge_val[31:24] = wdata_q[7:0];
                default: merge_val = bus.mem_read_data;
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_nxt  = state;
        read_en    = 1'b0;
        write_raw  = 1'b0;
        write_data = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fault_now ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!store_q) begin
                    read_en   = 1'b1;
                    state_nxt = RESP;
                end else if (funct3_q[1:0] == 2'b10) begin
                    write_raw  = 1'b1;
                    write_data = wdata_q;
                    state_nxt  = RESP;
                end else begin
                    read_en   = 1'b1;
                    state_nxt = MERGE;
                end
            end
            MERGE: begin
                write_raw  = 1'b1;
                write_data = merged_q;
                state_nxt  = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= bus.req_addr[ADDR_WIDTH+1:0];
                funct3_q <= bus.req_funct3;
                store_q  <= bus.req_store;
                wdata_q  <= bus.req_wdata;
                fault_q  <= fault_now;
                rdata_q  <= 32'h0;
            end
            if (state == ACCESS) begin
                if (!store_q) begin
                    rdata_q <= load_val;
                end else begin
                    merged_q <= merge_val;
                end
            end
            if (state == RESP && bus.resp_ready) begin
                rdata_q <= 32'h0;
                fault_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_fault     = fault_q;
    assign bus.mem_addr       = addr_q[ADDR_WIDTH+1:2];
    assign bus.mem_read_en    = read_en;
    // Gating with rst_n drops a pending RMW write in the very cycle reset arrives.
    assign bus.mem_write_en   = write_raw & rst_n;
    assign bus.mem_write_data = write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_mem = 1'b1;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(AW)) bus();

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:(1<<AW)-1];

    assign bus.mem_read_data = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_addr] <= bus.mem_write_data;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    int          lat, rd_cyc, wr_cyc;
    logic        both;
    logic [31:0] wr_data, r_rdata;
    logic [AW-1:0] wr_addr;
    logic        r_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        check("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1; rd_cyc = -1; wr_cyc = -1; both = 1'b0;
        wr_data = 32'h0; wr_addr = '0; r_rdata = 32'h0; r_fault = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.mem_read_en && rd_cyc < 0) rd_cyc = k;
            if (bus.mem_write_en && wr_cyc < 0) begin
                wr_cyc  = k;
                wr_data = bus.mem_write_data;
                wr_addr = bus.mem_addr;
            end
            if (bus.mem_read_en && bus.mem_write_en) both = 1'b1;
            if (bus.resp_valid) begin
                lat     = k;
                r_rdata = bus.resp_rdata;
                r_fault = bus.resp_fault;
            end
        end
        if (lat < 0) check("resp_timeout", {31'h0, bus.resp_valid}, 32'h1);
        check("rd_wr_exclusive", {31'h0, both}, 32'h0);
        if (bus.resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_fault", {31'h0, bus.resp_fault}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_rd_en",      {31'h0, bus.mem_read_en}, 32'h0);
        check("rst_wr_en",      {31'h0, bus.mem_write_en}, 32'h0);
        check("rst_wr_data",    bus.mem_write_data, 32'h0);
        check("rst_mem_addr",   {24'h0, bus.mem_addr}, 32'h0);
        check("rst_req_ready",  {31'h0, bus.req_ready}, 32'h1);
        clear_mem = 1'b0;
        rst_n = 1'b1;

        // SW then LW
        run_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF);
        check("sw_wr_cyc",  wr_cyc, 32'd1);
        check("sw_wr_addr", {24'h0, wr_addr}, 32'h04);
        check("sw_wr_data", wr_data, 32'hDEADBEEF);
        check("sw_no_read", rd_cyc, 32'hFFFF_FFFF);
        check("sw_lat",     lat, 32'd2);
        check("sw_rdata",   r_rdata, 32'h0);
        check("sw_mem4",    mem[4], 32'hDEADBEEF);

        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        check("lw_rd_cyc", rd_cyc, 32'd1);
        check("lw_lat",    lat, 32'd2);
        check("lw_rdata",  r_rdata, 32'hDEADBEEF);
        check("lw_fault",  {31'h0, r_fault}, 32'h0);

        // SB read-modify-write
        run_req(1'b1, 3'b000, 32'h0000_0012, 32'h0000_0055);
        check("sb_rd_cyc",  rd_cyc, 32'd1);
        check("sb_wr_cyc",  wr_cyc, 32'd2);
        check("sb_wr_data", wr_data, 32'hDE55BEEF);
        check("sb_wr_addr", {24'h0, wr_addr}, 32'h04);
        check("sb_lat",     lat, 32'd3);
        check("sb_mem4",    mem[4], 32'hDE55BEEF);

        run_req(1'b0, 3'b000, 32'h0000_0012, 32'h0);
        check("lb_12", r_rdata, 32'h0000_0055);
        run_req(1'b0, 3'b100, 32'h0000_0013, 32'h0);
        check("lbu_13", r_rdata, 32'h0000_00DE);
        run_req(1'b0, 3'b000, 32'h0000_0013, 32'h0);
        check("lb_13", r_rdata, 32'hFFFF_FFDE);
        run_req(1'b0, 3'b100, 32'h0000_0011, 32'h0);
        check("lbu_11", r_rdata, 32'h0000_00BE);

        // SH upper half, then signed/unsigned halfword loads
        run_req(1'b1, 3'b001, 32'h0000_0016, 32'h0000_8001);
        check("sh_wr_data", wr_data, 32'h8001_0000);
        check("sh_lat",     lat, 32'd3);
        check("sh_mem5",    mem[5], 32'h8001_0000);
        run_req(1'b0, 3'b001, 32'h0000_0016, 32'h0);
        check("lh_16", r_rdata, 32'hFFFF_8001);
        run_req(1'b0, 3'b101, 32'h0000_0016, 32'h0);
        check("lhu_16", r_rdata, 32'h0000_8001);
        run_req(1'b0, 3'b001, 32'h0000_0014, 32'h0);
        check("lh_14", r_rdata, 32'h0000_0000);

        // Upper address bits wrap
        run_req(1'b1, 3'b010, 32'h1000_0018, 32'h1234_5678);
        check("wrap_wr_addr", {24'h0, wr_addr}, 32'h06);
        check("wrap_mem6",    mem[6], 32'h1234_5678);

        // Faults never touch memory
        run_req(1'b0, 3'b010, 32'h0000_0011, 32'h0);
        check("flt_lw_lat",   lat, 32'd1);
        check("flt_lw_fault", {31'h0, r_fault}, 32'h1);
        check("flt_lw_rdata", r_rdata, 32'h0);
        check("flt_lw_noacc", {30'h0, rd_cyc < 0, wr_cyc < 0}, 32'h3);

        run_req(1'b1, 3'b001, 32'h0000_0013, 32'h0000_FFFF);
        check("flt_sh_lat",   lat, 32'd1);
        check("flt_sh_fault", {31'h0, r_fault}, 32'h1);
        check("flt_sh_noacc", {30'h0, rd_cyc < 0, wr_cyc < 0}, 32'h3);
        check("flt_sh_mem4",  mem[4], 32'hDE55BEEF);

        run_req(1'b0, 3'b011, 32'h0000_0010, 32'h0);
        check("flt_f3_lat",   lat, 32'd1);
        check("flt_f3_fault", {31'h0, r_fault}, 32'h1);
        check("flt_f3_rdata", r_rdata, 32'h0);
        check("flt_f3_noacc", {30'h0, rd_cyc < 0, wr_cyc < 0}, 32'h3);

        run_req(1'b1, 3'b100, 32'h0000_0010, 32'h0);
        check("flt_st_f3",    {31'h0, r_fault}, 32'h1);
        check("flt_st_noacc", {30'h0, rd_cyc < 0, wr_cyc < 0}, 32'h3);

        // Response back-pressure
        bus.resp_ready = 1'b0;
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        check("stall_lat", lat, 32'd2);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0020;
        bus.req_wdata  = 32'hA5A5_A5A5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, bus.resp_valid}, 32'h1);
            check("stall_rdata", bus.resp_rdata, 32'hDE55BEEF);
            check("stall_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_done_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("stall_done_ready", {31'h0, bus.req_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("stall_not_accepted", mem[8], 32'h0);

        // Reset during MERGE drops the write
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0000_0010;
        bus.req_wdata  = 32'h0000_0077;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("merge_wr_en", {31'h0, bus.mem_write_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("merge_rst_gate", {31'h0, bus.mem_write_en}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("mrst_mem4",      mem[4], 32'hDE55BEEF);
        check("mrst_valid",     {31'h0, bus.resp_valid}, 32'h0);
        check("mrst_rd_en",     {31'h0, bus.mem_read_en}, 32'h0);
        check("mrst_wr_en",     {31'h0, bus.mem_write_en}, 32'h0);
        check("mrst_wr_data",   bus.mem_write_data, 32'h0);
        check("mrst_mem_addr",  {24'h0, bus.mem_addr}, 32'h0);
        check("mrst_rdata",     bus.resp_rdata, 32'h0);
        check("mrst_fault",     {31'h0, bus.resp_fault}, 32'h0);
        check("mrst_req_ready", {31'h0, bus.req_ready}, 32'h1);

        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        check("post_rst_lw", r_rdata, 32'hDE55BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
